ula_sequenciador: RTL and testbench

Sequencer that sits directly upstream of the 4-bit ALU in the processor datapath and drains its registered result. It accepts one encoded instruction at a time over a valid/ready handshake, drives the ALU's operand, opcode and sign inputs for the required window, captures the 9-bit ALU result after the ALU's one-cycle registered latency, and presents it downstream over a second valid/ready handshake. It also flags unsupported opcodes and counts completed instructions.

---
 rtl/ula_sequenciador.sv | 112 +++++++++++
 tb/tb_ula_sequenciador.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - issues one instruction to the registered 4-bit ALU and hands its result downstream
module ula_sequenciador (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [12:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  output logic [3:0]  o_alu_a,
  output logic [3:0]  o_alu_b,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_sinal,
  input  logic [8:0]  i_alu_out,
  output logic [8:0]  o_res,
  output logic        o_res_err,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [7:0]  o_n_exec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_capture;
  logic        w_complete;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_alu_sinal;
  logic [8:0]  r_res;
  logic        r_res_err;
  logic [7:0]  r_n_exec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_instr_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        w_capture = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        if (i_res_ready) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ALU drive is held from accept until the next accept, so it is only loaded on w_accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_op    <= 4'd0;
      r_alu_sinal <= 1'b0;
      r_res_err   <= 1'b0;
      r_res       <= 9'd0;
      r_n_exec    <= 8'd0;
    end else begin
      if (w_accept) begin
        r_alu_sinal <= i_instr[12];
        r_alu_op    <= i_instr[11:8];
        r_alu_a     <= i_instr[7:4];
        r_alu_b     <= i_instr[3:0];
        r_res_err   <= (i_instr[11:8] == 4'd0) || i_instr[11];
      end
      if (w_capture) begin
        r_res <= i_alu_out;
      end
      if (w_complete) begin
        r_n_exec <= r_n_exec + 8'd1;
      end
    end
  end

  assign o_instr_ready = (r_state == S_IDLE) && i_rst_n;
  assign o_res_valid   = (r_state == S_DONE);
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_alu_sinal   = r_alu_sinal;
  assign o_res         = r_res;
  assign o_res_err     = r_res_err;
  assign o_n_exec      = r_n_exec;

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb/tb_ula_sequenciador.sv - randomized and directed bench for ula_sequenciador with a registered ALU stand-in
module tb_ula_sequenciador;

  logic        clk;
  logic        rst_n;
  logic [12:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_op;
  logic        alu_sinal;
  logic [8:0]  alu_out;
  logic [8:0]  res;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  n_exec;

  int checks;
  int failures;
  int cyc;
  int accept_cyc;
  int prev_accept;

  ula_sequenciador dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_instr      (instr),
    .i_instr_valid(instr_valid),
    .o_instr_ready(instr_ready),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_alu_sinal  (alu_sinal),
    .i_alu_out    (alu_out),
    .o_res        (res),
    .o_res_err    (res_err),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_n_exec     (n_exec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] alu_fn(input logic [12:0] f);
    int a;
    int b;
    int r;
    a = int'(f[7:4]);
    b = int'(f[3:0]);
    case (int'(f[11:8]))
      1: r = a + b;
      2: r = a - b;
      3: r = a * b;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = 15 - a;
      default: r = 0;
    endcase
    return 9'(r);
  endfunction

  // ALU stand-in: one-cycle registered latency on whatever the sequencer drives
  always @(posedge clk) alu_out <= alu_fn({alu_sinal, alu_op, alu_a, alu_b});

  // Transaction-level reference: busy from accept; result presented two edges later
  logic        m_busy;
  int          m_age;
  logic [12:0] m_f;
  logic [7:0]  m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_f    <= 13'd0;
      m_cnt  <= 8'd0;
    end else if (!m_busy) begin
      if (instr_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_f    <= instr;
      end
    end else if (m_age >= 2) begin
      if (res_ready) begin
        m_busy <= 1'b0;
        m_cnt  <= m_cnt + 8'd1;
      end
    end else begin
      m_age <= m_age + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic exp_valid;
      int   op;
      exp_valid = m_busy && (m_age == 2);
      op = int'(m_f[11:8]);
      chk("cyc_instr_ready", 32'(instr_ready), 32'(!m_busy));
      chk("cyc_res_valid", 32'(res_valid), 32'(exp_valid));
      chk("cyc_alu_fields", 32'({alu_sinal, alu_op, alu_a, alu_b}), 32'(m_f));
      chk("cyc_n_exec", 32'(n_exec), 32'(m_cnt));
      if (exp_valid) begin
        chk("cyc_res", 32'(res), 32'(alu_fn(m_f)));
        chk("cyc_res_err", 32'(res_err), 32'((op == 0) || (op > 7)));
      end
    end
  end

  task automatic send(input logic [12:0] v);
    int n;
    @(negedge clk);
    #1;
    instr = v;
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: instr_ready stayed %0b expected 1", instr_ready);
    end
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [8:0] er, input logic ee);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_valid"}, 32'(res_valid), 32'd1);
    chk({name, "_res"}, 32'(res), 32'(er));
    chk({name, "_err"}, 32'(res_err), 32'(ee));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(instr_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] held;
    logic       rnd_done;
    checks = 0;
    failures = 0;
    cyc = 0;
    instr = 13'd0;
    instr_valid = 1'b0;
    res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    chk("rst_outputs", 32'({res_valid, res, res_err, n_exec, alu_a, alu_b, alu_op, alu_sinal}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_after", 32'(instr_ready), 32'd1);

    // Multiply 3*5, exact edge timing
    send({1'b0, 4'b0011, 4'd3, 4'd5});
    chk("e0_alu_op", 32'(alu_op), 32'd3);
    chk("e0_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("e1_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("e2_valid", 32'(res_valid), 32'd1);
    chk("e2_res", 32'(res), 32'd15);
    chk("e2_err", 32'(res_err), 32'd0);
    @(posedge clk); #1;
    chk("e3_valid", 32'(res_valid), 32'd0);
    chk("e3_ready", 32'(instr_ready), 32'd1);
    chk("e3_n_exec", 32'(n_exec), 32'd1);

    // Back-to-back AND then XOR
    send({1'b0, 4'b0100, 4'hC, 4'hA});
    prev_accept = accept_cyc;
    wait_result("and", 9'd8, 1'b0);
    send({1'b0, 4'b0110, 4'b1010, 4'b0110});
    chk("ii_spacing", 32'(accept_cyc - prev_accept), 32'd4);
    wait_result("xor", 9'd12, 1'b0);

    send({1'b0, 4'b1000, 4'hF, 4'hF});
    wait_result("bad_op", 9'd0, 1'b1);
    wait_idle();
    chk("bad_op_count", 32'(n_exec), 32'd4);

    // Backpressure, with instr_valid pulses that must be ignored
    res_ready = 1'b0;
    send({1'b1, 4'b0101, 4'd9, 4'd6});
    wait_result("bp", 9'd15, 1'b0);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      instr_valid = (i % 2) == 0;
      instr = 13'($urandom);
    end
    chk("bp_res_held", 32'(res), 32'(held));
    chk("bp_ready_low", 32'(instr_ready), 32'd0);
    chk("bp_alu_held", 32'({alu_sinal, alu_op, alu_a, alu_b}), 32'({1'b1, 4'b0101, 4'd9, 4'd6}));
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_release_ready", 32'(instr_ready), 32'd1);
    chk("bp_count", 32'(n_exec), 32'd5);

    // Asynchronous reset while in WAIT
    send({1'b0, 4'b0001, 4'd7, 4'd8});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({res_valid, res, res_err, n_exec, alu_a, alu_b, alu_op, alu_sinal}), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send({1'b0, 4'b0010, 4'd2, 4'd5});
    wait_result("post_rst", 9'h1FD, 1'b0);
    wait_idle();
    chk("post_rst_count", 32'(n_exec), 32'd1);

    // Random traffic with random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(13'($urandom));
        end
        wait_idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    chk("rnd_count", 32'(n_exec), 32'd61);

    // Counter wrap
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 256; i++) send(13'($urandom));
    wait_idle();
    chk("wrap_256", 32'(n_exec), 32'd0);
    send({1'b0, 4'b0011, 4'd15, 4'd15});
    wait_result("wrap_257", 9'd225, 1'b0);
    wait_idle();
    chk("wrap_257_count", 32'(n_exec), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
